// File: rtl/inst_rom_ctrl_pkg.sv
// Shared definitions for the instruction ROM responder and its loader.
// Holds the bus widths and types, the zero word that doubles as a NOP,
// the reset level, the loader state encodings and a byte-lane helper.
package inst_rom_ctrl_pkg;

  localparam int InstBusWidth     = 32;
  localparam int InstAddrBusWidth = 32;

  typedef logic [InstBusWidth-1:0]     inst_bus_t;
  typedef logic [InstAddrBusWidth-1:0] inst_addr_bus_t;

  localparam inst_bus_t ZeroWord   = '0;
  localparam logic      RstEnableN = 1'b0;

  typedef enum logic [1:0] {
    LdIdle = 2'b00,
    LdLoad = 2'b01,
    LdDone = 2'b10
  } ld_state_e;

  // Drops a byte into the big-endian lane selected by the byte counter:
  // byte 0 of a word lands in bits 31:24 and byte 3 in bits 7:0.
  function automatic inst_bus_t place_byte(input inst_bus_t word,
                                           input logic [7:0] data,
                                           input logic [1:0] bcnt);
    inst_bus_t res;
    res = word;
    case (bcnt)
      2'd0:    res[31:24] = data;
      2'd1:    res[23:16] = data;
      2'd2:    res[15:8]  = data;
      default: res[7:0]   = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/inst_rom_ctrl_mem.sv
// Word array behind the instruction ROM responder.
// Ports:
//   clk    - write clock
//   we     - write enable, sampled on the rising edge
//   waddr  - word index to write
//   wdata  - word to write
//   raddr  - word index to read
//   rdata  - asynchronous read data
// The contents are deliberately not reset, so a reset during or after
// loading leaves already-written words in place.
module inst_rom_mem
  import inst_rom_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  inst_bus_t             wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output inst_bus_t             rdata
);

  localparam int Depth = 1 << DEPTH_LOG2;

  inst_bus_t mem [0:Depth-1];

  // Single synchronous write port. A read of the same word in the write
  // cycle therefore still sees the old contents until the edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_rom_ctrl.sv
// Instruction-memory responder for the core's fetch port, with a
// byte-stream loader that packs bytes big-endian into words.
// Ports:
//   clk, rst        - clock and asynchronous active-low reset
//   ce_i, addr_i    - fetch enable and byte address from the core
//   inst_o          - fetched word, zero for disabled or bad fetches
//   ld_start_i      - pulse that (re)starts loading at word 0
//   ld_valid_i      - loader byte valid
//   ld_byte_i       - loader byte
//   ld_last_i       - current byte is the last of the image
//   ld_ready_o      - loader can accept a byte
//   core_hold_o     - keep the core in reset while loading
//   word_cnt_o      - words written since the last start
//   err_o           - sticky misaligned/out-of-range fetch flag
module inst_rom_ctrl
  import inst_rom_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  inst_addr_bus_t        addr_i,
  output inst_bus_t             inst_o,
  input  logic                  ld_start_i,
  input  logic                  ld_valid_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_last_i,
  output logic                  ld_ready_o,
  output logic                  core_hold_o,
  output logic [DEPTH_LOG2:0]   word_cnt_o,
  output logic                  err_o
);

  ld_state_e             state, state_nxt;
  logic [DEPTH_LOG2-1:0] wptr;
  logic [1:0]            bcnt;
  inst_bus_t             buffer;
  inst_bus_t             wdata;
  inst_bus_t             rdata;
  logic [DEPTH_LOG2:0]   word_cnt;
  logic                  accept;
  logic                  wr_en;
  logic                  misaligned;
  logic                  out_of_range;

  // A start pulse takes priority over a byte presented at the same edge,
  // so the byte is refused rather than landing in the fresh image.
  assign accept = ld_valid_i & ld_ready_o & ~ld_start_i;

  // The buffer keeps the lower lanes zero, so merging the current byte
  // yields both the next buffer value and a zero-filled final word.
  assign wdata = place_byte(buffer, ld_byte_i, bcnt);
  assign wr_en = accept & ((bcnt == 2'd3) | ld_last_i);

  inst_rom_mem #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wptr),
    .wdata(wdata),
    .raddr(addr_i[DEPTH_LOG2+1:2]),
    .rdata(rdata)
  );

  // Fetch decode: only enabled, word-aligned, in-range addresses return
  // array data; everything else reads as a NOP.
  assign misaligned   = |addr_i[1:0];
  assign out_of_range = |addr_i[InstAddrBusWidth-1:DEPTH_LOG2+2];
  assign inst_o       = (ce_i && !misaligned && !out_of_range) ? rdata : ZeroWord;

  // Loader state register.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnableN) begin
      state <= LdIdle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode. Loading ends either on the last byte of
  // the image or when the final array slot is written, whichever is first.
  always_comb begin
    state_nxt   = state;
    ld_ready_o  = 1'b0;
    core_hold_o = 1'b0;
    case (state)
      LdIdle: begin
        if (ld_start_i) state_nxt = LdLoad;
      end
      LdLoad: begin
        ld_ready_o  = 1'b1;
        core_hold_o = 1'b1;
        if (ld_start_i) begin
          state_nxt = LdLoad;
        end else if (wr_en && (ld_last_i || (&wptr))) begin
          state_nxt = LdDone;
        end
      end
      LdDone: begin
        if (ld_start_i) state_nxt = LdLoad;
      end
      default: state_nxt = LdIdle;
    endcase
  end

  // Byte packer and word pointer. A start discards any partial word and
  // rewinds to word 0; a completed word is committed and the buffer is
  // cleared so the next word starts zero-filled.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnableN) begin
      wptr     <= '0;
      bcnt     <= '0;
      buffer   <= ZeroWord;
      word_cnt <= '0;
    end else if (ld_start_i) begin
      wptr     <= '0;
      bcnt     <= '0;
      buffer   <= ZeroWord;
      word_cnt <= '0;
    end else if (wr_en) begin
      wptr     <= wptr + 1'b1;
      word_cnt <= word_cnt + 1'b1;
      bcnt     <= '0;
      buffer   <= ZeroWord;
    end else if (accept) begin
      buffer   <= wdata;
      bcnt     <= bcnt + 1'b1;
    end
  end

  assign word_cnt_o = word_cnt;

  // Sticky fetch-error flag, cleared only by reset or a new load.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnableN) begin
      err_o <= 1'b0;
    end else if (ld_start_i) begin
      err_o <= 1'b0;
    end else if (ce_i && (misaligned || out_of_range)) begin
      err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Directed bench for inst_rom_ctrl: a 1024-word instance for loading,
// fetch and error behaviour, and a 4-word instance for the full-array case.
module tb_inst_rom_ctrl;
  import inst_rom_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst;

  logic        ce_a, start_a, valid_a, last_a, ready_a, hold_a, err_a;
  logic [31:0] addr_a, inst_a;
  logic [7:0]  byte_a;
  logic [10:0] cnt_a;

  logic        ce_b, start_b, valid_b, last_b, ready_b, hold_b, err_b;
  logic [31:0] addr_b, inst_b;
  logic [7:0]  byte_b;
  logic [2:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  inst_rom_ctrl #(.DEPTH_LOG2(10)) dut_a (
    .clk(clk), .rst(rst), .ce_i(ce_a), .addr_i(addr_a), .inst_o(inst_a),
    .ld_start_i(start_a), .ld_valid_i(valid_a), .ld_byte_i(byte_a),
    .ld_last_i(last_a), .ld_ready_o(ready_a), .core_hold_o(hold_a),
    .word_cnt_o(cnt_a), .err_o(err_a)
  );

  inst_rom_ctrl #(.DEPTH_LOG2(2)) dut_b (
    .clk(clk), .rst(rst), .ce_i(ce_b), .addr_i(addr_b), .inst_o(inst_b),
    .ld_start_i(start_b), .ld_valid_i(valid_b), .ld_byte_i(byte_b),
    .ld_last_i(last_b), .ld_ready_o(ready_b), .core_hold_o(hold_b),
    .word_cnt_o(cnt_b), .err_o(err_b)
  );

  // Records what the next observation should be.
  task automatic expectVal(input string tag, input logic [31:0] value);
    exp_q.push_back(value);
    tag_q.push_back(tag);
  endtask

  // Pops the oldest expectation and compares it with an observation.
  task automatic checkOutput(input logic [31:0] observed);
    logic [31:0] expected;
    string       tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_empty observed=%h", observed);
    end else begin
      expected = exp_q.pop_front();
      tag      = tag_q.pop_front();
      assert (observed === expected) else begin
        errors++;
        $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  // Drives one cycle of loader inputs on the large instance.
  task automatic applyStimulus(input logic st, input logic v, input logic l,
                               input logic [7:0] b);
    start_a = st; valid_a = v; last_a = l; byte_a = b;
    @(posedge clk); #1;
    start_a = 1'b0; valid_a = 1'b0; last_a = 1'b0;
  endtask

  // Drives one cycle of loader inputs on the small instance.
  task automatic applyStimulusB(input logic st, input logic v, input logic l,
                                input logic [7:0] b);
    start_b = st; valid_b = v; last_b = l; byte_b = b;
    @(posedge clk); #1;
    start_b = 1'b0; valid_b = 1'b0; last_b = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] img [0:7];
    img[0] = 8'h34; img[1] = 8'h01; img[2] = 8'h00; img[3] = 8'h20;
    img[4] = 8'h24; img[5] = 8'h02; img[6] = 8'h00; img[7] = 8'h04;

    rst = 1'b0;
    ce_a = 0; addr_a = 0; start_a = 0; valid_a = 0; last_a = 0; byte_a = 0;
    ce_b = 0; addr_b = 0; start_b = 0; valid_b = 0; last_b = 0; byte_b = 0;
    #17;
    rst = 1'b1;
    @(posedge clk); #1;

    expectVal("reset_inst", 32'd0);    checkOutput(inst_a);
    expectVal("reset_ready", 32'd0);   checkOutput({31'd0, ready_a});
    expectVal("reset_hold", 32'd0);    checkOutput({31'd0, hold_a});
    expectVal("reset_err", 32'd0);     checkOutput({31'd0, err_a});
    expectVal("reset_cnt", 32'd0);     checkOutput({21'd0, cnt_a});
    expectVal("reset_ready_b", 32'd0); checkOutput({31'd0, ready_b});

    applyStimulus(1, 0, 0, 8'h00);
    expectVal("start_ready", 32'd1);   checkOutput({31'd0, ready_a});
    expectVal("start_hold", 32'd1);    checkOutput({31'd0, hold_a});
    for (int i = 0; i < 8; i++) applyStimulus(0, 1, (i == 7), img[i]);
    expectVal("load_cnt", 32'd2);      checkOutput({21'd0, cnt_a});
    expectVal("load_ready", 32'd0);    checkOutput({31'd0, ready_a});
    expectVal("load_hold", 32'd0);     checkOutput({31'd0, hold_a});
    ce_a = 1; addr_a = 32'h0; #1;
    expectVal("fetch_0", 32'h34010020); checkOutput(inst_a);
    addr_a = 32'h4; #1;
    expectVal("fetch_4", 32'h24020004); checkOutput(inst_a);
    ce_a = 0; #1;
    expectVal("fetch_ce_off", 32'd0);  checkOutput(inst_a);
    @(posedge clk); #1;

    applyStimulus(1, 0, 0, 8'h00);
    ce_a = 1; addr_a = 32'h0;
    applyStimulus(0, 1, 0, 8'h55);
    applyStimulus(0, 1, 0, 8'h66);
    applyStimulus(0, 1, 0, 8'h77);
    valid_a = 1; last_a = 1; byte_a = 8'h88; #1;
    expectVal("same_word_old", 32'h34010020); checkOutput(inst_a);
    @(posedge clk); #1;
    valid_a = 0; last_a = 0;
    expectVal("same_word_new", 32'h55667788); checkOutput(inst_a);
    expectVal("same_word_cnt", 32'd1); checkOutput({21'd0, cnt_a});
    ce_a = 0;

    applyStimulus(1, 0, 0, 8'h00);
    applyStimulus(0, 1, 0, 8'hAA);
    applyStimulus(0, 1, 1, 8'hBB);
    expectVal("partial_cnt", 32'd1);   checkOutput({21'd0, cnt_a});
    ce_a = 1; addr_a = 32'h0; #1;
    expectVal("partial_word", 32'hAABB0000); checkOutput(inst_a);
    addr_a = 32'h4; #1;
    expectVal("partial_kept", 32'h24020004); checkOutput(inst_a);

    addr_a = 32'h2; #1;
    expectVal("misalign_inst", 32'd0); checkOutput(inst_a);
    expectVal("misalign_err_pre", 32'd0); checkOutput({31'd0, err_a});
    @(posedge clk); #1;
    ce_a = 0;
    expectVal("misalign_err", 32'd1);  checkOutput({31'd0, err_a});
    @(posedge clk); #1;
    expectVal("err_sticky", 32'd1);    checkOutput({31'd0, err_a});
    applyStimulus(1, 0, 0, 8'h00);
    expectVal("err_cleared", 32'd0);   checkOutput({31'd0, err_a});
    ce_a = 1; addr_a = 32'h1000; #1;
    expectVal("range_inst", 32'd0);    checkOutput(inst_a);
    @(posedge clk); #1;
    ce_a = 0;
    expectVal("range_err", 32'd1);     checkOutput({31'd0, err_a});

    applyStimulus(0, 1, 0, 8'h01);
    applyStimulus(0, 1, 0, 8'h02);
    applyStimulus(0, 1, 0, 8'h03);
    applyStimulus(1, 1, 0, 8'hEE);
    expectVal("restart_err", 32'd0);   checkOutput({31'd0, err_a});
    expectVal("restart_cnt0", 32'd0);  checkOutput({21'd0, cnt_a});
    applyStimulus(0, 1, 0, 8'h11);
    applyStimulus(0, 1, 0, 8'h22);
    applyStimulus(0, 1, 0, 8'h33);
    applyStimulus(0, 1, 1, 8'h44);
    ce_a = 1; addr_a = 32'h0; #1;
    expectVal("restart_word", 32'h11223344); checkOutput(inst_a);
    expectVal("restart_cnt", 32'd1);   checkOutput({21'd0, cnt_a});
    ce_a = 0;

    applyStimulusB(1, 0, 0, 8'h00);
    for (int i = 1; i <= 16; i++) applyStimulusB(0, 1, 0, 8'(i));
    expectVal("full_cnt", 32'd4);      checkOutput({29'd0, cnt_b});
    expectVal("full_ready", 32'd0);    checkOutput({31'd0, ready_b});
    expectVal("full_hold", 32'd0);     checkOutput({31'd0, hold_b});
    for (int i = 17; i <= 20; i++) applyStimulusB(0, 1, 0, 8'(i));
    expectVal("full_cnt_after", 32'd4); checkOutput({29'd0, cnt_b});
    ce_b = 1; addr_b = 32'hC; #1;
    expectVal("full_word3", 32'h0D0E0F10); checkOutput(inst_b);
    addr_b = 32'h0; #1;
    expectVal("full_word0", 32'h01020304); checkOutput(inst_b);
    addr_b = 32'h10; #1;
    expectVal("small_range_inst", 32'd0); checkOutput(inst_b);
    @(posedge clk); #1;
    ce_b = 0;
    expectVal("small_range_err", 32'd1); checkOutput({31'd0, err_b});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
